// File: rtl/mdu.sv
// -----------------------------------------------------------------------------
// mdu -- multi-cycle multiply/divide unit owning the MIPS HI/LO registers.
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   reset      synchronous, active-high; clears HI/LO, busy, counter, pending
//   start      qualifies op in this cycle
//   op         0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 NONE
//   A, B       operands from register-file read ports rs / rt
//   busy       registered; high while a mult/div is in flight
//   HI, LO     registered HI / LO architectural registers
//   dbg_state  current FSM state (0 IDLE, 1 BUSY) for checker binding
//
// Handshake: start acts as "valid" and !busy as "ready". A request is
// accepted only on an edge where start=1 and busy=0; while busy=1 every
// request (including MTHI/MTLO) is dropped and the issuer must stall and
// hold it until busy falls.
//
// The result is computed combinationally from the operands at the launch
// edge and parked in pending registers; HI/LO only change at the commit
// edge, N cycles later, so they stay stable for the whole busy window.
// -----------------------------------------------------------------------------
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        dbg_state
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  // Counter is loaded with N-1 at launch and commits when it reads zero,
  // which places the commit exactly N edges after launch.
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [31:0]      r_pend_hi;
  logic [31:0]      r_pend_lo;
  logic             r_pend_we;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic w_idle;
  logic w_is_mult;
  logic w_is_div;
  logic w_launch;
  logic w_mthi;
  logic w_mtlo;

  assign w_idle    = (r_state == S_IDLE);
  assign w_is_mult = (op == OP_MULT) || (op == OP_MULTU);
  assign w_is_div  = (op == OP_DIV)  || (op == OP_DIVU);
  assign w_launch  = start && w_idle && (w_is_mult || w_is_div);
  assign w_mthi    = start && w_idle && (op == OP_MTHI);
  assign w_mtlo    = start && w_idle && (op == OP_MTLO);

  // ---------------------------------------------------------------------------
  // Multiplier: one 64-bit multiply of sign- or zero-extended operands.
  // The low 64 bits of the extended product equal the signed/unsigned
  // 32x32 product in both cases.
  // ---------------------------------------------------------------------------
  logic        w_mul_sgn;
  logic [63:0] w_a64;
  logic [63:0] w_b64;
  logic [63:0] w_prod;

  assign w_mul_sgn = (op == OP_MULT);
  assign w_a64     = {{32{w_mul_sgn & A[31]}}, A};
  assign w_b64     = {{32{w_mul_sgn & B[31]}}, B};
  assign w_prod    = w_a64 * w_b64;

  // ---------------------------------------------------------------------------
  // Divider: unsigned divide of magnitudes, then restore signs. Quotient is
  // negative when operand signs differ; remainder follows the dividend.
  // 0x80000000 / -1 falls out naturally: |A| = 0x80000000, q_mag = 0x80000000,
  // negation wraps back to 0x80000000 and the remainder is zero.
  // ---------------------------------------------------------------------------
  logic        w_div_sgn;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic        w_b_zero;
  logic [31:0] w_divisor;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_quot;
  logic [31:0] w_rem;

  assign w_div_sgn = (op == OP_DIV);
  assign w_a_neg   = w_div_sgn & A[31];
  assign w_b_neg   = w_div_sgn & B[31];
  assign w_a_mag   = w_a_neg ? (~A + 32'd1) : A;
  assign w_b_mag   = w_b_neg ? (~B + 32'd1) : B;
  assign w_b_zero  = (B == 32'd0);
  // Divide by one when B is zero so the datapath never sees x/0; the
  // result is discarded anyway via r_pend_we.
  assign w_divisor = w_b_zero ? 32'd1 : w_b_mag;
  assign w_q_mag   = w_a_mag / w_divisor;
  assign w_r_mag   = w_a_mag % w_divisor;
  assign w_quot    = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
  assign w_rem     = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;

  // ---------------------------------------------------------------------------
  // FSM, counter, pending result and architectural HI/LO
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
      r_pend_we <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_launch) begin
            r_state <= S_BUSY;
            if (w_is_mult) begin
              r_cnt     <= MULT_LOAD;
              r_pend_hi <= w_prod[63:32];
              r_pend_lo <= w_prod[31:0];
              r_pend_we <= 1'b1;
            end else begin
              r_cnt     <= DIV_LOAD;
              r_pend_hi <= w_rem;
              r_pend_lo <= w_quot;
              r_pend_we <= !w_b_zero;
            end
          end else begin
            if (w_mthi) r_hi <= A;
            if (w_mtlo) r_lo <= A;
          end
        end
        S_BUSY: begin
          if (r_cnt == '0) begin
            r_state <= S_IDLE;
            if (r_pend_we) begin
              r_hi <= r_pend_hi;
              r_lo <= r_pend_lo;
            end
            r_pend_we <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = (r_state == S_BUSY);
  assign HI        = r_hi;
  assign LO        = r_lo;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mdu.sv
// -----------------------------------------------------------------------------
// tb_mdu -- self-checking bench for mdu. Expected {HI,LO} pairs are pushed to
// exp_q when an operation is issued and popped when the unit finishes.
// -----------------------------------------------------------------------------
module tb_mdu;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        dbg_state;

  always #5 clk = ~clk;

  mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .HI(HI), .LO(LO), .dbg_state(dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [63:0] exp_q[$];
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  int checks   = 0;
  int failures = 0;

  // Reference model: returns the {HI,LO} the unit should hold after op.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa, sb, sq, sr;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      3'd1: begin p = 64'(sa * sb); return p; end
      3'd2: begin p = {32'd0, a} * {32'd0, b}; return p; end
      3'd3: begin
        if (b == 32'd0) return {m_hi, m_lo};
        sq = sa / sb;
        sr = sa % sb;
        return {sr[31:0], sq[31:0]};
      end
      3'd4: begin
        if (b == 32'd0) return {m_hi, m_lo};
        return {a % b, a / b};
      end
      3'd5: return {a, m_lo};
      3'd6: return {m_hi, a};
      default: return {m_hi, m_lo};
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Presents a request for exactly one edge, then scrambles the operands so
  // any late sampling inside the unit would show up as a wrong result.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    A     = a;
    B     = b;
    tick();
    start = 1'b0;
    op    = 3'd0;
    A     = $urandom;
    B     = $urandom;
  endtask

  // Counts edges until busy drops, noting whether HI/LO moved meanwhile.
  task automatic wait_idle(output int cycles, output bit stable, output bit timeout);
    logic [31:0] h0, l0;
    h0      = HI;
    l0      = LO;
    cycles  = 0;
    stable  = 1'b1;
    timeout = 1'b0;
    while (busy === 1'b1) begin
      if (HI !== h0 || LO !== l0) stable = 1'b0;
      tick();
      cycles++;
      if (cycles > 200) begin
        timeout = 1'b1;
        break;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    op    = 3'd0;
    A     = 32'd0;
    B     = 32'd0;
    tick();
    tick();
    reset = 1'b0;
    m_hi  = 32'd0;
    m_lo  = 32'd0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (HI !== 32'd0) begin failures++; $display("FAIL reset_hi got=%h exp=0", HI); end
    checks++; if (LO !== 32'd0) begin failures++; $display("FAIL reset_lo got=%h exp=0", LO); end
  endtask

  task automatic test_mt;
    logic [63:0] e;
    exp_q.push_back({m_hi, 32'h12345678});
    issue(3'd6, 32'h12345678, 32'h0);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mtlo_busy got=%b exp=0", busy); end
    e = exp_q.pop_front();
    checks++; if ({HI, LO} !== e) begin failures++; $display("FAIL mtlo got=%h exp=%h", {HI, LO}, e); end
    {m_hi, m_lo} = e;
    exp_q.push_back(model(3'd5, 32'hCAFEF00D, 32'h0));
    issue(3'd5, 32'hCAFEF00D, 32'h0);
    e = exp_q.pop_front();
    checks++; if ({HI, LO} !== e) begin failures++; $display("FAIL mthi got=%h exp=%h", {HI, LO}, e); end
    {m_hi, m_lo} = e;
    // start=0 and reserved op 7 must leave everything alone
    op = 3'd6; A = 32'h1; start = 1'b0;
    tick();
    start = 1'b1; op = 3'd7;
    tick();
    start = 1'b0; op = 3'd0;
    checks++; if ({busy, HI, LO} !== {1'b0, m_hi, m_lo}) begin
      failures++; $display("FAIL nop got=%h exp=%h", {busy, HI, LO}, {1'b0, m_hi, m_lo});
    end
  endtask

  // Launch one mult/div, check latency, stability and committed value.
  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp_v, input int n);
    int cyc; bit st, to;
    logic [63:0] e;
    exp_q.push_back(exp_v);
    issue(o, a, b);
    wait_idle(cyc, st, to);
    checks++; if (to || cyc != n) begin
      failures++; $display("FAIL %s_latency got=%0d exp=%0d timeout=%0b", name, cyc, n, to);
    end
    checks++; if (!st) begin failures++; $display("FAIL %s_stable got=moved exp=held", name); end
    if (exp_q.size() == 0) begin
      checks++; failures++; $display("FAIL %s_queue got=empty exp=entry", name);
    end else begin
      e = exp_q.pop_front();
      checks++; if ({HI, LO} !== e) begin failures++; $display("FAIL %s got=%h exp=%h", name, {HI, LO}, e); end
      {m_hi, m_lo} = e;
    end
  endtask

  task automatic test_mult;
    run_op("mult", 3'd1, 32'hFFFFFFFE, 32'd3, 64'hFFFFFFFF_FFFFFFFA, MULT_N);
    run_op("multu", 3'd2, 32'hFFFFFFFF, 32'd2, 64'h00000001_FFFFFFFE, MULT_N);
  endtask

  task automatic test_div;
    run_op("div", 3'd3, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, DIV_N);
    run_op("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, DIV_N);
    run_op("divu", 3'd4, 32'd100, 32'd7, 64'h00000002_0000000E, DIV_N);
  endtask

  task automatic test_divzero_ignored;
    int cyc; bit st, to;
    logic [63:0] e;
    issue(3'd5, 32'hAAAA0000, 32'h0);
    issue(3'd6, 32'h0000BBBB, 32'h0);
    m_hi = 32'hAAAA0000; m_lo = 32'h0000BBBB;
    exp_q.push_back(64'hAAAA0000_0000BBBB);
    issue(3'd4, 32'h12345678, 32'd0);
    issue(3'd5, 32'h55555555, 32'h0);          // MTHI while busy: dropped
    issue(3'd1, 32'd9, 32'd9);                 // MULT while busy: dropped
    checks++; if (HI !== 32'hAAAA0000) begin failures++; $display("FAIL mthi_ignored got=%h exp=aaaa0000", HI); end
    wait_idle(cyc, st, to);
    checks++; if (to || cyc + 2 != DIV_N) begin
      failures++; $display("FAIL divzero_latency got=%0d exp=%0d", cyc + 2, DIV_N);
    end
    e = exp_q.pop_front();
    checks++; if ({HI, LO} !== e) begin failures++; $display("FAIL divzero got=%h exp=%h", {HI, LO}, e); end
    // the dropped MULT must not have started after the divide
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ignored_launch got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid;
    issue(3'd1, 32'd7, 32'd6);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    m_hi = 32'd0; m_lo = 32'd0;
    checks++; if ({busy, HI, LO} !== 65'd0) begin
      failures++; $display("FAIL reset_mid got=%h exp=0", {busy, HI, LO});
    end
    // stability check inside run_op also proves 42 never commits
    run_op("post_reset_divu", 3'd4, 32'd100, 32'd7, 64'h00000002_0000000E, DIV_N);
  endtask

  task automatic test_back_to_back;
    run_op("b2b_multu", 3'd2, 32'h0001_0000, 32'h0001_0000, 64'h00000001_00000000, MULT_N);
    run_op("b2b_div", 3'd3, 32'd50, 32'hFFFFFFF9, 64'h00000001_FFFFFFF9, DIV_N);
  endtask

  task automatic test_random;
    logic [2:0]  o;
    logic [31:0] a, b;
    for (int i = 0; i < 12; i++) begin
      o = 3'($urandom_range(1, 4));
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 28);
      run_op("rand", o, a, b, model(o, a, b), (o <= 3'd2) ? MULT_N : DIV_N);
    end
  endtask

  initial begin
    test_reset();
    test_mt();
    test_mult();
    test_div();
    test_divzero_ignored();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
